dvp_frame_tx: RTL

- DVP-style camera transmitter: the sending end of the PCLK/VSYNC/HREF capture interface in the FPGA register block.
- Pops 32-bit words from a show-ahead FIFO and serializes each word as four bytes, MSB first.
- Generates pixel clock, VSYNC and HREF framing so the existing capture path, or an external sink, can be driven from memory.
- Used for loopback test of the camera capture path and as a video source.

---
 rtl/dvp_frame_tx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dvp_frame_tx.sv
// dvp_frame_tx: DVP camera transmitter, serializes FIFO words into PCLK/VSYNC/HREF/DATA frames.
// Optional test pattern source is enabled by defining DVP_TX_TEST_PATTERN_EN.
module dvp_frame_tx #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BLANK  = 16,
   parameter int V_FRONT  = 8,
   parameter int V_BACK   = 8,
   parameter int CNTW     = 12
) (
   input  logic        WBs_CLK_i,
   input  logic        WBs_RST_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic        underrun_o,
   input  logic [31:0] word_i,
   input  logic        word_valid_i,
   output logic        word_pop_o,
   input  logic        pattern_sel_i,
   output logic        PCLK_o,
   output logic        VSYNC_o,
   output logic        HREF_o,
   output logic [7:0]  DATA_o
);
   typedef enum logic [2:0] {IDLE, VFRONT, LINE, HBLANK, VBACK} state_t;
   state_t          r_state, w_nstate;
   logic            r_phase, r_stall, r_busy, r_done, r_under, r_pclk, r_vsync, r_href;
   logic [7:0]      r_data;
   logic [31:0]     r_shift;
   logic [CNTW-1:0] r_cnt, r_line, w_lim, w_ncnt;
   logic            w_last, w_need, w_pop, w_pat;
`ifdef DVP_TX_TEST_PATTERN_EN
   logic r_pat;
   // pattern select is captured with the accepted start and held for the frame
   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i)
      if (WBs_RST_i) r_pat <= 1'b0;
      else if (r_state == IDLE && start_i) r_pat <= pattern_sel_i;
   assign w_pat = r_pat;
`else
   logic w_unused;
   assign w_unused = pattern_sel_i;
   assign w_pat    = 1'b0;
`endif
   // tick limit of the current state, successor state and the word-fetch request
   always_comb begin
      w_lim = r_state == VFRONT ? CNTW'(V_FRONT - 1) :
              r_state == LINE   ? CNTW'(H_ACTIVE - 1) :
              r_state == HBLANK ? CNTW'(H_BLANK - 1) : CNTW'(V_BACK - 1);
      w_last = r_cnt == w_lim;
      w_ncnt = w_last ? '0 : r_cnt + 1'b1;
      w_nstate = r_state;
      if (w_last)
         w_nstate = (r_state == VFRONT || r_state == HBLANK) ? LINE :
                    r_state == LINE  ? (r_line == CNTW'(V_ACTIVE - 1) ? VBACK : HBLANK) :
                    r_state == VBACK ? IDLE : r_state;
      w_need = r_stall | (r_phase && r_state != IDLE && w_nstate == LINE && w_ncnt[1:0] == 2'd0 && !w_pat);
      w_pop = w_need & word_valid_i;
   end
   // frame sequencer: tick phases, counters, framing outputs and byte serializer
   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         r_state <= IDLE;
         r_phase <= 1'b0;
         r_stall <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_under <= 1'b0;
         r_pclk  <= 1'b0;
         r_vsync <= 1'b0;
         r_href  <= 1'b0;
         r_data  <= 8'h00;
         r_shift <= 32'h0;
         r_cnt   <= '0;
         r_line  <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_state == IDLE) begin
            r_pclk <= 1'b0;
            if (start_i) begin
               r_state <= VFRONT;
               r_busy  <= 1'b1;
               r_under <= 1'b0;
               r_vsync <= 1'b1;
               r_href  <= 1'b0;
               r_cnt   <= '0;
               r_line  <= '0;
               r_phase <= 1'b0;
            end
         end else if (!r_phase) begin
            if (!r_stall) begin
               r_phase <= 1'b1;
               r_pclk  <= 1'b1;
            end else if (word_valid_i) begin
               r_stall <= 1'b0;
               r_shift <= word_i;
               r_data  <= word_i[31:24];
            end
         end else begin
            r_phase <= 1'b0;
            r_pclk  <= 1'b0;
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_vsync <= w_nstate != IDLE;
            r_href  <= w_nstate == LINE;
            if (r_state == LINE && w_last) r_line <= r_line + 1'b1;
            if (w_nstate == IDLE) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
            if (w_nstate != LINE) r_data <= 8'h00;
            else if (w_pat) r_data <= w_ncnt == '0 ? 8'h00 : r_data + 8'h01;
            else if (w_ncnt[1:0] != 2'd0) begin
               r_data  <= r_shift[23:16];
               r_shift <= {r_shift[23:0], 8'h00};
            end else if (word_valid_i) begin
               r_shift <= word_i;
               r_data  <= word_i[31:24];
            end else begin
               r_stall <= 1'b1;
               r_under <= 1'b1;
            end
         end
      end
   end
   assign busy_o       = r_busy;
   assign frame_done_o = r_done;
   assign underrun_o   = r_under;
   assign word_pop_o   = w_pop;
   assign PCLK_o       = r_pclk;
   assign VSYNC_o      = r_vsync;
   assign HREF_o       = r_href;
   assign DATA_o       = r_data;
endmodule
